vector_load_unit: RTL and testbench

- Memory-read stage that sits directly upstream of the result write-back stage.
- On a start pulse, issues sequential reads from data memory: I items for a vector op, one item for a scalar op.
- Assembles the returned words into a packed vector register image or a scalar word, then pulses finished.
- Output vector and item layout match the write-back stage's vector_data input (item k at bits [k*L +: L]).

---
 rtl/asip_vec_pkg.sv | 39 +++
 rtl/vector_item_inserter.sv | 48 ++++
 rtl/vector_load_unit.sv | 199 +++++++++++++++++++
 tb/tb_vector_load_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/asip_vec_pkg.sv
// -----------------------------------------------------------------------------
// asip_vec_pkg
// Shared definitions for the vector load path of the ASIP datapath.
//   - Default geometry: items per vector, item width, memory address width.
//   - Operation encoding used on op_type (scalar / vector load).
//   - Load FSM state encoding.
//   - Helper to size an item index from an item count.
// -----------------------------------------------------------------------------
package asip_vec_pkg;

   // Default geometry of a vector register image and of data memory.
   localparam int unsigned VEC_ITEMS  = 32'd20;
   localparam int unsigned ITEM_WIDTH = 32'd32;
   localparam int unsigned ADDR_WIDTH = 32'd10;

   // op_type encoding, sampled together with start.
   localparam logic OP_SCALAR = 1'b0;
   localparam logic OP_VECTOR = 1'b1;

   // Load sequencer states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } vlu_state_e;

   // Width of an index that can address n items; never narrower than 1 bit.
   function automatic int unsigned idx_width(input int unsigned n);
      int unsigned w;
      if (n > 32'd1) begin
         w = $clog2(n);
      end else begin
         w = 32'd1;
      end
      return w;
   endfunction

endpackage

// File: rtl/vector_item_inserter.sv
// -----------------------------------------------------------------------------
// vector_item_inserter
// Registered vector image of I items of L bits. On wr_en the item selected by
// idx is replaced by item; all other items hold. Counterpart of the item
// extractor in the write-back stage: item k lives at bits [k*L +: L].
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low clear of the whole image
//   wr_en    write strobe
//   idx      item index to overwrite (indices >= I are ignored)
//   item     new item value
//   vec_o    packed vector image, [I-1:0][L-1:0] flattened
// -----------------------------------------------------------------------------
module vector_item_inserter
   import asip_vec_pkg::*;
#(
   parameter int unsigned I     = VEC_ITEMS,
   parameter int unsigned L     = ITEM_WIDTH,
   parameter int unsigned IDX_W = idx_width(I)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wr_en,
   input  logic [IDX_W-1:0]   idx,
   input  logic [L-1:0]       item,
   output logic [I*L-1:0]     vec_o
);

   logic [I-1:0][L-1:0] vec_q;

   // Per-item write: only the addressed item is replaced, the rest hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_q <= '0;
      end else begin
         for (int k = 0; k < int'(I); k++) begin
            if (wr_en && (idx == IDX_W'(k))) begin
               vec_q[k] <= item;
            end else begin
               vec_q[k] <= vec_q[k];
            end
         end
      end
   end

   assign vec_o = vec_q;

endmodule

// File: rtl/vector_load_unit.sv
// -----------------------------------------------------------------------------
// vector_load_unit
// Memory-read stage feeding result write-back. A start pulse in IDLE launches
// I sequential reads (vector op) or one read (scalar op) from base_address,
// assembles the returned words and pulses finished once the result is whole.
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset (aborts any load in flight)
//   start         one-cycle request, honoured only in IDLE
//   op_type       1 = vector load, 0 = scalar load (sampled with start)
//   base_address  first memory address (sampled with start)
//   read_data     memory data, valid the cycle after read_en
//   read_en       memory read strobe
//   read_address  memory read address, 0 whenever read_en is low
//   vector_data   assembled vector, item k at [k*L +: L]
//   scalar_data   assembled scalar
//   busy          high in every state except IDLE
//   finished      one-cycle completion pulse (DONE state)
// -----------------------------------------------------------------------------
module vector_load_unit
   import asip_vec_pkg::*;
#(
   parameter int unsigned I = VEC_ITEMS,
   parameter int unsigned L = ITEM_WIDTH,
   parameter int unsigned A = ADDR_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op_type,
   input  logic [A-1:0]     base_address,
   input  logic [L-1:0]     read_data,
   output logic             read_en,
   output logic [A-1:0]     read_address,
   output logic [I*L-1:0]   vector_data,
   output logic [L-1:0]     scalar_data,
   output logic             busy,
   output logic             finished
);

   localparam int unsigned IDX_W = idx_width(I);

   // Counter value of the last issued read for each op type.
   localparam logic [A-1:0] LAST_VEC    = A'(I - 32'd1);
   localparam logic [A-1:0] LAST_SCALAR = '0;

   vlu_state_e     state_q, state_d;
   logic [A-1:0]   counter_q, counter_d;
   logic           op_q, op_d;
   logic [A-1:0]   base_q, base_d;

   logic           read_en_q, read_en_d;
   logic [A-1:0]   read_address_q, read_address_d;
   logic           busy_q, busy_d;
   logic           finished_q, finished_d;

   logic           cap_valid_q;
   logic [IDX_W-1:0] cap_idx_q;
   logic [L-1:0]   scalar_q;

   logic           last_issue_s;
   logic           vec_wr_s;

   // Last read of the op is being issued this cycle.
   always_comb begin
      if (op_q == OP_VECTOR) begin
         last_issue_s = (counter_q == LAST_VEC);
      end else begin
         last_issue_s = (counter_q == LAST_SCALAR);
      end
   end

   // State register together with the request context latched at start.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         counter_q <= '0;
         op_q      <= OP_SCALAR;
         base_q    <= '0;
      end else begin
         state_q   <= state_d;
         counter_q <= counter_d;
         op_q      <= op_d;
         base_q    <= base_d;
      end
   end

   // Next-state logic; start outside IDLE is dropped, not queued.
   always_comb begin
      state_d   = state_q;
      counter_d = counter_q;
      op_d      = op_q;
      base_d    = base_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = ISSUE;
               counter_d = '0;
               op_d      = op_type;
               base_d    = base_address;
            end else begin
               state_d   = IDLE;
            end
         end
         ISSUE: begin
            counter_d = counter_q + {{(A-1){1'b0}}, 1'b1};
            if (last_issue_s) begin
               state_d = DRAIN;
            end else begin
               state_d = ISSUE;
            end
         end
         DRAIN: begin
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output decode from the next state so the outputs can be registered
   // yet still line up with the state they describe.
   always_comb begin
      if (state_d == ISSUE) begin
         read_en_d = 1'b1;
         // Address wraps modulo 2^A by construction of the A-bit sum.
         read_address_d = base_d + counter_d;
      end else begin
         read_en_d      = 1'b0;
         read_address_d = '0;
      end
      busy_d     = (state_d != IDLE);
      finished_d = (state_d == DONE);
   end

   // Registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         read_en_q      <= 1'b0;
         read_address_q <= '0;
         busy_q         <= 1'b0;
         finished_q     <= 1'b0;
      end else begin
         read_en_q      <= read_en_d;
         read_address_q <= read_address_d;
         busy_q         <= busy_d;
         finished_q     <= finished_d;
      end
   end

   // Capture pipeline: read_data belongs to the read issued one cycle earlier,
   // so the strobe and the item index are delayed by one cycle to match it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cap_valid_q <= 1'b0;
         cap_idx_q   <= '0;
      end else begin
         cap_valid_q <= read_en_q;
         cap_idx_q   <= counter_q[IDX_W-1:0];
      end
   end

   // Scalar result; untouched by vector ops.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scalar_q <= '0;
      end else if (cap_valid_q && (op_q == OP_SCALAR)) begin
         scalar_q <= read_data;
      end else begin
         scalar_q <= scalar_q;
      end
   end

   assign vec_wr_s = cap_valid_q && (op_q == OP_VECTOR);

   vector_item_inserter #(
      .I     (I),
      .L     (L),
      .IDX_W (IDX_W)
   ) u_inserter (
      .clk   (clk),
      .rst_n (rst),
      .wr_en (vec_wr_s),
      .idx   (cap_idx_q),
      .item  (read_data),
      .vec_o (vector_data)
   );

   assign read_en      = read_en_q;
   assign read_address = read_address_q;
   assign scalar_data  = scalar_q;
   assign busy         = busy_q;
   assign finished     = finished_q;

endmodule

// File: tb/tb_vector_load_unit.sv
// -----------------------------------------------------------------------------
// tb_vector_load_unit
// Bench for vector_load_unit: a memory model answers reads one cycle late, a
// cycle-phase reference model predicts every output, a compare process checks
// them each falling edge, and directed plus random loads drive the DUT.
// -----------------------------------------------------------------------------
module tb_vector_load_unit;

   localparam int I     = 20;
   localparam int L     = 32;
   localparam int A     = 10;
   localparam int MEMSZ = 1 << A;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             op_type;
   logic [A-1:0]     base_address;
   logic [L-1:0]     read_data = '0;
   logic             read_en;
   logic [A-1:0]     read_address;
   logic [I*L-1:0]   vector_data;
   logic [L-1:0]     scalar_data;
   logic             busy;
   logic             finished;

   always #5 clk = ~clk;

   vector_load_unit #(.I(I), .L(L), .A(A)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .op_type      (op_type),
      .base_address (base_address),
      .read_data    (read_data),
      .read_en      (read_en),
      .read_address (read_address),
      .vector_data  (vector_data),
      .scalar_data  (scalar_data),
      .busy         (busy),
      .finished     (finished)
   );

   logic [L-1:0] mem [0:MEMSZ-1];

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [I*L-1:0] act, input logic [I*L-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory answers one cycle after read_en; garbage otherwise.
   always @(posedge clk) begin
      read_data <= read_en ? mem[read_address] : L'($urandom);
   end

   // Reference model: phase = cycles elapsed since the accepted start edge.
   int                 m_phase = 0;
   int                 m_n     = 1;
   int                 m_base  = 0;
   logic               m_op    = 1'b0;
   logic [I-1:0][L-1:0] m_vec  = '0;
   logic [L-1:0]       m_sc    = '0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_phase <= 0;
         m_vec   <= '0;
         m_sc    <= '0;
      end else if (m_phase == 0) begin
         if (start) begin
            m_phase <= 1;
            m_op    <= op_type;
            m_base  <= int'(base_address);
            m_n     <= op_type ? I : 1;
         end
      end else if (m_phase == m_n + 2) begin
         m_phase <= 0;
      end else begin
         m_phase <= m_phase + 1;
         if (m_phase + 1 == m_n + 2) begin
            if (m_op) begin
               for (int k = 0; k < I; k++) m_vec[k] <= mem[(m_base + k) % MEMSZ];
            end else begin
               m_sc <= mem[m_base];
            end
         end
      end
   end

   // Per-cycle comparison against the model.
   logic         e_en;
   logic [A-1:0] e_addr;
   always @(negedge clk) begin
      e_en   = (m_phase >= 1) && (m_phase <= m_n);
      e_addr = e_en ? A'((m_base + m_phase - 1) % MEMSZ) : '0;
      check("read_en", read_en, e_en);
      check("read_address", read_address, e_addr);
      check("busy", busy, m_phase != 0);
      check("finished", finished, m_phase == m_n + 2);
      if (m_phase == 0 || m_phase == m_n + 2 || !m_op) check("vector_data", vector_data, m_vec);
      if (m_phase == 0 || m_phase == m_n + 2 || m_op)  check("scalar_data", scalar_data, m_sc);
   end

   // One load; returns at the falling edge of the finished cycle.
   task automatic do_load(input logic op, input logic [A-1:0] base, input bit hold,
                          output int lat, output int nreads, output logic [A-1:0] a5);
      @(posedge clk); #2;
      start = 1'b1; op_type = op; base_address = base;
      @(posedge clk); #2;
      if (!hold) start = 1'b0;
      lat = 0; nreads = 0; a5 = '0;
      do begin
         @(negedge clk);
         lat++;
         if (read_en) nreads++;
         if (lat == 5) a5 = read_address;
      end while (!finished && lat < 60);
      check("finish_timeout", finished, 1'b1);
      if (hold) begin
         @(posedge clk); #2;
         start = 1'b0;
      end
   endtask

   int           lat, lat2, nr, nfin;
   logic [A-1:0] a5;
   logic [L-1:0] v;

   initial begin
      rst = 1'b0; start = 1'b0; op_type = 1'b0; base_address = '0;
      for (int a = 0; a < MEMSZ; a++) mem[a] = L'(a * 3);
      repeat (3) @(posedge clk);
      #1;
      check("rst_read_en", read_en, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_vector", vector_data, '0);
      check("rst_scalar", scalar_data, '0);
      @(posedge clk); #2; rst = 1'b1;

      // Vector load, base 100, mem[a] = a*3.
      do_load(1'b1, 10'd100, 1'b0, lat, nr, a5);
      check("vec_latency", lat, 22);
      check("vec_nreads", nr, 20);
      check("vec_addr_cycle5", a5, 10'd104);
      check("vec_item0", vector_data[0*L +: L], 32'd300);
      check("vec_item5", vector_data[5*L +: L], 32'd315);
      check("vec_item19", vector_data[19*L +: L], 32'd357);

      // Scalar load, base 5.
      mem[5] = 32'hDEADBEEF;
      do_load(1'b0, 10'd5, 1'b0, lat, nr, a5);
      check("sc_latency", lat, 3);
      check("sc_nreads", nr, 1);
      check("sc_value", scalar_data, 32'hDEADBEEF);
      check("sc_vec_kept", vector_data[0*L +: L], 32'd300);

      // Address wrap-around from 1020.
      mem[0] = 32'h0BADF00D;
      do_load(1'b1, 10'd1020, 1'b0, lat, nr, a5);
      check("wrap_latency", lat, 22);
      check("wrap_addr_cycle5", a5, 10'd0);
      check("wrap_item4", vector_data[4*L +: L], 32'h0BADF00D);
      check("wrap_item3", vector_data[3*L +: L], 32'd3069);

      // start held through the op and into DONE: exactly one load.
      do_load(1'b1, 10'd200, 1'b1, lat, nr, a5);
      check("hold_latency", lat, 22);
      check("hold_nreads", nr, 20);
      repeat (3) @(negedge clk);
      check("hold_no_restart", busy, 1'b0);

      // Back-to-back: vector then scalar started the cycle after finished.
      do_load(1'b1, 10'd300, 1'b0, lat, nr, a5);
      do_load(1'b0, 10'd7, 1'b0, lat2, nr, a5);
      check("b2b_vec_latency", lat, 22);
      check("b2b_sc_latency", lat2, 3);
      check("b2b_vec_kept", vector_data[0*L +: L], 32'd900);
      check("b2b_scalar", scalar_data, 32'd21);

      // Reset in cycle 7 of a vector load.
      @(posedge clk); #2;
      start = 1'b1; op_type = 1'b1; base_address = 10'd400;
      @(posedge clk); #2; start = 1'b0;
      repeat (7) @(negedge clk);
      #1 rst = 1'b0;
      #1;
      check("midrst_read_en", read_en, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_vector", vector_data, '0);
      check("midrst_scalar", scalar_data, '0);
      @(posedge clk); #2; rst = 1'b1;
      nfin = 0;
      repeat (30) begin
         @(negedge clk);
         if (finished) nfin++;
      end
      check("midrst_no_finish", nfin, 0);

      // Randomized loads with fresh memory contents between ops.
      repeat (40) begin
         repeat (64) begin
            v = L'($urandom);
            mem[$urandom_range(MEMSZ - 1, 0)] = v;
         end
         repeat ($urandom_range(3, 0)) @(posedge clk);
         op_type = 1'($urandom);
         do_load(op_type, A'($urandom), ($urandom_range(3, 0) == 0), lat, nr, a5);
         check("rnd_latency", lat, (op_type ? 22 : 3));
         check("rnd_nreads", nr, (op_type ? 20 : 1));
      end

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
